mm_match_ctrl: RTL and testbench



---
 rtl/mm_match_ctrl.sv | 141 ++++++++++++++
 tb/tb_mm_match_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_match_ctrl.sv
// Matching-memory controller: pairs tokens by key across a bank of
// key/data/valid cells. A token that finds a partner emits the operand pair
// and frees the cell. A token with no partner is parked in the lowest free cell.
module mm_match_ctrl #(
  parameter int NUM_CELLS = 8,
  parameter int KEY_W     = 28,
  parameter int DATA_W    = 32,
  localparam int OCC_W    = $clog2(NUM_CELLS + 1),
  localparam int IDX_W    = $clog2(NUM_CELLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KEY_W-1:0]  out_key,
  output logic [DATA_W-1:0] out_data_st,
  output logic [DATA_W-1:0] out_data_in,
  output logic [OCC_W-1:0]  occupancy,
  output logic              full,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, SEARCH, EMIT} state_t;

  state_t                state_q;
  logic [KEY_W-1:0]      tok_key_q;
  logic [DATA_W-1:0]     tok_data_q;
  logic [NUM_CELLS-1:0]  valid_q;
  logic [KEY_W-1:0]      cell_key_q  [NUM_CELLS];
  logic [DATA_W-1:0]     cell_data_q [NUM_CELLS];
  logic [OCC_W-1:0]      occ_q;
  logic                  ovf_q;
  logic                  out_valid_q;
  logic [KEY_W-1:0]      out_key_q;
  logic [DATA_W-1:0]     out_st_q;
  logic [DATA_W-1:0]     out_in_q;

  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic                  free_any;
  logic [IDX_W-1:0]      free_idx;

  // Priority search: scanning downward leaves the lowest matching / free index
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (valid_q[i] && (cell_key_q[i] == tok_key_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Control FSM: token capture, search outcome, pair hand-off, flush
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tok_key_q   <= '0;
      tok_data_q  <= '0;
      valid_q     <= '0;
      occ_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_key_q   <= '0;
      out_st_q    <= '0;
      out_in_q    <= '0;
    end else if (flush) begin
      // Any in-flight token or pending pair is simply dropped
      state_q     <= IDLE;
      valid_q     <= '0;
      occ_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            tok_key_q  <= in_key;
            tok_data_q <= in_data;
            state_q    <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            out_key_q        <= tok_key_q;
            out_st_q         <= cell_data_q[hit_idx];
            out_in_q         <= tok_data_q;
            out_valid_q      <= 1'b1;
            valid_q[hit_idx] <= 1'b0;
            occ_q            <= occ_q - OCC_W'(1);
            state_q          <= EMIT;
          end else if (free_any) begin
            valid_q[free_idx] <= 1'b1;
            occ_q             <= occ_q + OCC_W'(1);
            state_q           <= IDLE;
          end else begin
            ovf_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Cell payload storage, written on allocation only (never reset)
  always_ff @(posedge clk) begin
    if (!rst && !flush && (state_q == SEARCH) && !hit && free_any) begin
      cell_key_q[free_idx]  <= tok_key_q;
      cell_data_q[free_idx] <= tok_data_q;
    end
  end

  assign in_ready    = (state_q == IDLE) && !flush;
  assign out_valid   = out_valid_q;
  assign out_key     = out_key_q;
  assign out_data_st = out_st_q;
  assign out_data_in = out_in_q;
  assign occupancy   = occ_q;
  assign full        = (occ_q == OCC_W'(NUM_CELLS));
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_mm_match_ctrl.sv
// Scoreboard bench for mm_match_ctrl: a cell-bank reference model predicts
// pairs into a queue, and a monitor pops and compares on each handshake.
module tb_mm_match_ctrl;
  localparam int N  = 8;
  localparam int KW = 28;
  localparam int DW = 32;
  localparam int OW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic [KW-1:0] in_key, out_key;
  logic [DW-1:0] in_data, out_data_st, out_data_in;
  logic          out_valid, out_ready, full, ovf;
  logic [OW-1:0] occupancy;

  mm_match_ctrl #(.NUM_CELLS(N), .KEY_W(KW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key),
    .out_data_st(out_data_st), .out_data_in(out_data_in),
    .occupancy(occupancy), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: a bank of parked tokens plus the sticky drop flag
  bit            m_vld  [N];
  logic [KW-1:0] m_key  [N];
  logic [DW-1:0] m_data [N];
  bit            m_ovf;
  logic [KW-1:0] exp_key [$];
  logic [DW-1:0] exp_st  [$];
  logic [DW-1:0] exp_in  [$];

  bit hold = 1'b1;
  bit rnd  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_vld[i]) c++;
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
    m_ovf = 1'b0;
    exp_key.delete(); exp_st.delete(); exp_in.delete();
  endtask

  // A token pairs with the oldest-position equal key, else parks in the first hole
  task automatic model_apply(input logic [KW-1:0] k, input logic [DW-1:0] d, output bit hit);
    int idx = -1;
    for (int i = 0; i < N; i++) if (idx < 0 && m_vld[i] && m_key[i] == k) idx = i;
    hit = (idx >= 0);
    if (hit) begin
      exp_key.push_back(k); exp_st.push_back(m_data[idx]); exp_in.push_back(d);
      m_vld[idx] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) if (idx < 0 && !m_vld[i]) idx = i;
      if (idx >= 0) begin
        m_vld[idx] = 1'b1; m_key[idx] = k; m_data[idx] = d;
      end else m_ovf = 1'b1;
    end
  endtask

  task automatic post_chk();
    chk("occupancy", occupancy, m_count());
    chk("ovf", ovf, m_ovf);
    chk("full", full, m_count() == N);
  endtask

  task automatic send(input logic [KW-1:0] k, input logic [DW-1:0] d, input bit wait_done);
    int t = 0;
    bit hit;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    chk("accept_wait", in_ready, 1);
    if (!in_ready) return;
    in_valid = 1'b1; in_key = k; in_data = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_apply(k, d, hit);
    if (!hit) begin
      @(negedge clk) chk("miss_in_ready_T1", in_ready, 0);
      @(negedge clk) chk("miss_in_ready_T2", in_ready, 1);
      post_chk();
    end else if (wait_done) begin
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin @(negedge clk); t++; end
      chk("hit_done_wait", in_ready, 1);
      post_chk();
    end
  endtask

  task automatic flush_pulse();
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk) chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    model_clear();
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_occupancy", occupancy, 0);
    chk("flush_ovf", ovf, 0);
    chk("flush_in_ready_after", in_ready, 1);
  endtask

  // downstream acceptance pattern
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold)     out_ready = 1'b0;
      else if (rnd) out_ready = ($urandom_range(0, 2) != 0);
      else          out_ready = 1'b1;
    end
  end

  // monitor: pair scoreboard, back-pressure stability, in_ready exclusion
  initial begin
    logic pv, pr, pf;
    logic [KW-1:0] pk;
    logic [DW-1:0] ps, pi;
    pv = 1'b0; pr = 1'b0; pf = 1'b0; pk = '0; ps = '0; pi = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) chk("in_ready_during_emit", in_ready, 0);
        if (pv && !pr && !pf) begin
          chk("hold_out_valid", out_valid, 1);
          chk("hold_out_key", out_key, pk);
          chk("hold_out_data_st", out_data_st, ps);
          chk("hold_out_data_in", out_data_in, pi);
        end
        if (out_valid && out_ready) begin
          if (exp_key.size() == 0) chk("unexpected_pair", 1, 0);
          else begin
            chk("out_key", out_key, exp_key.pop_front());
            chk("out_data_st", out_data_st, exp_st.pop_front());
            chk("out_data_in", out_data_in, exp_in.pop_front());
          end
        end
      end
      pv = out_valid; pr = out_ready; pf = flush;
      pk = out_key; ps = out_data_st; pi = out_data_in;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_key = '0; in_data = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_key", out_key, 0);
    chk("rst_out_data_st", out_data_st, 0);
    chk("rst_out_data_in", out_data_in, 0);
    hold = 1'b0;

    // basic store then match
    send(28'h0000123, 32'hAAAA0001, 1'b1);
    send(28'h0000123, 32'hBBBB0002, 1'b1);

    // match held by back-pressure for five cycles
    send(28'h0000123, 32'hC0000001, 1'b1);
    hold = 1'b1;
    send(28'h0000123, 32'hC0000002, 1'b0);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    post_chk();

    // fill every cell, overflow, then free one by a match
    flush_pulse();
    for (int k = 1; k <= N; k++) send(KW'(k), $urandom, 1'b1);
    send(28'h9, $urandom, 1'b1);
    chk("ovf_set", ovf, 1);
    chk("full_set", full, 1);
    send(28'h3, $urandom, 1'b1);
    chk("after_ovf_full", full, 0);

    // duplicate keys resolve lowest index first
    flush_pulse();
    send(28'h5, 32'h11, 1'b1);
    send(28'h5, 32'h22, 1'b1);
    send(28'h5, 32'h33, 1'b1);
    send(28'h5, 32'h44, 1'b1);

    // flush while a pair is pending
    flush_pulse();
    for (int k = 16; k < 20; k++) send(KW'(k), $urandom, 1'b1);
    hold = 1'b1;
    send(28'h11, 32'hDEAD0011, 1'b0);
    @(negedge clk);
    @(negedge clk) chk("pre_flush_out_valid", out_valid, 1);
    flush_pulse();
    hold = 1'b0;
    send(28'h1, 32'h00000001, 1'b1);

    // randomized traffic with random back-pressure
    flush_pulse();
    rnd = 1'b1;
    for (int i = 0; i < 300; i++) send(KW'($urandom_range(1, 12)), $urandom, 1'b1);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_key.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
